// File: rtl/phy_arbiter_if.sv
// Requester/PHY bundle for phy_arbiter: link enable, two requester
// handshakes and the registered word stream toward the transmitter.
interface phy_arbiter_if;
  logic        link_en;
  logic [31:0] data_in0;
  logic        valid_in0;
  logic        ready_out0;
  logic [31:0] data_in1;
  logic        valid_in1;
  logic        ready_out1;
  logic [31:0] data_out;
  logic        valid_out;
  logic        grant_id;
  logic        link_up;

  modport master (
    output link_en, data_in0, valid_in0, data_in1, valid_in1,
    input  ready_out0, ready_out1, data_out, valid_out, grant_id, link_up
  );

  modport slave (
    input  link_en, data_in0, valid_in0, data_in1, valid_in1,
    output ready_out0, ready_out1, data_out, valid_out, grant_id, link_up
  );
endinterface

// File: rtl/phy_arbiter.sv
// Slot-based two-requester arbiter feeding a PHY word stream (IDLE/INIT/ACTIVE).
// Optional macro PHY_ARB_STRICT_PRIO_EN: requester 0 always wins over requester 1.
module phy_arbiter #(
  parameter int          SLOT_LEN   = 32,
  parameter int          INIT_WORDS = 4,
  parameter logic [31:0] IDLE_WORD  = 32'hBCBCBCBC
) (
  input logic           clk_32f,
  input logic           reset,
  phy_arbiter_if.slave  bus
);

  localparam logic [7:0] SLOT_LAST = 8'(SLOT_LEN - 1);
  localparam logic [7:0] INIT_LAST = 8'(INIT_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_ACTIVE} state_t;

  state_t      state, state_p0;
  logic [7:0]  slot_cnt;
  logic [7:0]  init_cnt, init_p0;
  logic        boundary;
  logic        ptr, ptr_p0;
  logic        win0;
  logic        rdy0, rdy1;
  logic [31:0] data_p0, data_p1;
  logic        vld_p0, vld_p1;
  logic        grant_p0, grant_p1;
  logic        link_p1;

  assign boundary = (slot_cnt == SLOT_LAST);

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      slot_cnt <= '0;
    end else if (boundary) begin
      slot_cnt <= '0;
    end else begin
      slot_cnt <= slot_cnt + 8'd1;
    end
  end

  // Pointer names the last granted requester; the other one wins a tie.
  always_comb begin
    win0 = 1'b0;
`ifdef PHY_ARB_STRICT_PRIO_EN
    win0 = bus.valid_in0;
`else
    win0 = bus.valid_in0 & (~bus.valid_in1 | ptr);
`endif
  end

  // Next-state and next-output decode; nothing moves outside a boundary cycle.
  always_comb begin
    state_p0 = state;
    init_p0  = init_cnt;
    ptr_p0   = ptr;
    data_p0  = data_p1;
    vld_p0   = vld_p1;
    grant_p0 = grant_p1;
    rdy0     = 1'b0;
    rdy1     = 1'b0;
    if (boundary) begin
      data_p0 = '0;
      vld_p0  = 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.link_en) begin
            state_p0 = S_INIT;
            init_p0  = '0;
            data_p0  = IDLE_WORD;
          end
        end
        S_INIT: begin
          if (!bus.link_en) begin
            state_p0 = S_IDLE;
          end else if (init_cnt == INIT_LAST) begin
            state_p0 = S_ACTIVE;
          end else begin
            init_p0 = init_cnt + 8'd1;
            data_p0 = IDLE_WORD;
          end
        end
        S_ACTIVE: begin
          // Link drop wins over arbitration: no ready pulse, no capture.
          if (!bus.link_en) begin
            state_p0 = S_IDLE;
          end else if (win0) begin
            rdy0     = 1'b1;
            data_p0  = bus.data_in0;
            vld_p0   = 1'b1;
            grant_p0 = 1'b0;
            ptr_p0   = 1'b0;
          end else if (bus.valid_in1) begin
            rdy1     = 1'b1;
            data_p0  = bus.data_in1;
            vld_p0   = 1'b1;
            grant_p0 = 1'b1;
            ptr_p0   = 1'b1;
          end
        end
        default: state_p0 = S_IDLE;
      endcase
    end
  end

  // Output stage: registered word, valid, grant and link status.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      init_cnt <= '0;
      ptr      <= 1'b1;
      data_p1  <= '0;
      vld_p1   <= 1'b0;
      grant_p1 <= 1'b0;
      link_p1  <= 1'b0;
    end else begin
      state    <= state_p0;
      init_cnt <= init_p0;
      ptr      <= ptr_p0;
      data_p1  <= data_p0;
      vld_p1   <= vld_p0;
      grant_p1 <= grant_p0;
      link_p1  <= (state_p0 == S_ACTIVE);
    end
  end

  assign bus.ready_out0 = rdy0;
  assign bus.ready_out1 = rdy1;
  assign bus.data_out   = data_p1;
  assign bus.valid_out  = vld_p1;
  assign bus.grant_id   = grant_p1;
  assign bus.link_up    = link_p1;

endmodule

// File: tb/tb_phy_arbiter.sv
// Directed bench for phy_arbiter: training sequence, table of ACTIVE slots,
// link drop/re-raise and mid-slot reset.
module tb_phy_arbiter;
  localparam int SLOT = 32;
`ifdef PHY_ARB_STRICT_PRIO_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  phy_arbiter_if bus();

  phy_arbiter #(.SLOT_LEN(SLOT), .INIT_WORDS(4), .IDLE_WORD(32'hBCBCBCBC)) dut (
    .clk_32f (clk),
    .reset   (reset),
    .bus     (bus)
  );

  typedef struct {
    logic        v0, v1;
    logic [31:0] d0, d1;
    logic        r0, r1;
    logic [31:0] dout;
    logic        vout, gid;
  } vec_t;

  vec_t vecs[10];

  int   tests = 0;
  int   fails = 0;
  int   stray;
  int   changes;
  logic r0b, r1b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Runs one slot from count 0 through the boundary edge; drop_at >= 0 lowers link_en mid-slot.
  task automatic run_slot(input int drop_at);
    logic [34:0] held;
    held    = {bus.data_out, bus.valid_out, bus.grant_id, bus.link_up};
    stray   = 0;
    changes = 0;
    for (int i = 0; i < SLOT - 1; i++) begin
      if (i == drop_at) begin
        bus.link_en = 1'b0;
        #1;
      end
      if (bus.ready_out0 || bus.ready_out1) stray++;
      if ({bus.data_out, bus.valid_out, bus.grant_id, bus.link_up} !== held) changes++;
      tick();
    end
    r0b = bus.ready_out0;
    r1b = bus.ready_out1;
    tick();
  endtask

  task automatic check_slot(input string name, input logic e0, input logic e1,
                            input logic [31:0] d, input logic v, input logic g, input logic l);
    check({name, ".stray_ready"}, stray, 0);
    check({name, ".hold"}, changes, 0);
    check({name, ".ready0"}, {31'd0, r0b}, {31'd0, e0});
    check({name, ".ready1"}, {31'd0, r1b}, {31'd0, e1});
    check({name, ".data"}, bus.data_out, d);
    check({name, ".valid"}, {31'd0, bus.valid_out}, {31'd0, v});
    check({name, ".grant"}, {31'd0, bus.grant_id}, {31'd0, g});
    check({name, ".link_up"}, {31'd0, bus.link_up}, {31'd0, l});
  endtask

  initial begin
    vecs[0] = '{1, 1, 32'hA0A0A0A0, 32'hB1B1B1B1, 1, 0, 32'hA0A0A0A0, 1, 0};
    vecs[1] = STRICT ? '{1, 1, 32'hA0A0A0A0, 32'hB1B1B1B1, 1, 0, 32'hA0A0A0A0, 1, 0}
                     : '{1, 1, 32'hA0A0A0A0, 32'hB1B1B1B1, 0, 1, 32'hB1B1B1B1, 1, 1};
    vecs[2] = '{1, 1, 32'hA0A0A0A0, 32'hB1B1B1B1, 1, 0, 32'hA0A0A0A0, 1, 0};
    vecs[3] = STRICT ? '{1, 1, 32'hA0A0A0A0, 32'hB1B1B1B1, 1, 0, 32'hA0A0A0A0, 1, 0}
                     : '{1, 1, 32'hA0A0A0A0, 32'hB1B1B1B1, 0, 1, 32'hB1B1B1B1, 1, 1};
    vecs[4] = '{0, 0, 32'h77777777, 32'h88888888, 0, 0, 32'h0, 0, STRICT ? 1'b0 : 1'b1};
    vecs[5] = '{1, 0, 32'h12345678, 32'h99999999, 1, 0, 32'h12345678, 1, 0};
    vecs[6] = '{0, 1, 32'hDEADBEEF, 32'hCAFEF00D, 0, 1, 32'hCAFEF00D, 1, 1};
    vecs[7] = '{0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0, 1};
    vecs[8] = '{1, 1, 32'h11111111, 32'h22222222, 1, 0, 32'h11111111, 1, 0};
    vecs[9] = STRICT ? '{1, 1, 32'h11111111, 32'h22222222, 1, 0, 32'h11111111, 1, 0}
                     : '{1, 1, 32'h11111111, 32'h22222222, 0, 1, 32'h22222222, 1, 1};

    reset         = 1'b1;
    bus.link_en   = 1'b1;
    bus.data_in0  = 32'h0;
    bus.valid_in0 = 1'b1;
    bus.data_in1  = 32'h0;
    bus.valid_in1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.data", bus.data_out, 32'h0);
    check("rst.flags", {28'd0, bus.valid_out, bus.grant_id, bus.link_up, bus.ready_out0}, 32'h0);
    bus.valid_in0 = 1'b0;
    tick();
    reset = 1'b0;

    // Training: IDLE->INIT edge plus three INIT slots of IDLE_WORD, then ACTIVE.
    for (int s = 0; s < 4; s++) begin
      run_slot(-1);
      check_slot($sformatf("train%0d", s), 0, 0, 32'hBCBCBCBC, 0, 0, 0);
    end
    run_slot(-1);
    check_slot("to_active", 0, 0, 32'h0, 0, 0, 1);

    for (int i = 0; i < 10; i++) begin
      bus.valid_in0 = vecs[i].v0;
      bus.valid_in1 = vecs[i].v1;
      bus.data_in0  = vecs[i].d0;
      bus.data_in1  = vecs[i].d1;
      #1;
      run_slot(-1);
      check_slot($sformatf("vec%0d", i), vecs[i].r0, vecs[i].r1, vecs[i].dout,
                 vecs[i].vout, vecs[i].gid, 1'b1);
    end

    // Link drop mid-slot with both requesters valid.
    bus.valid_in0 = 1'b1;
    bus.valid_in1 = 1'b1;
    bus.data_in0  = 32'hA0A0A0A0;
    bus.data_in1  = 32'hB1B1B1B1;
    #1;
    run_slot(10);
    check_slot("drop", 0, 0, 32'h0, 0, STRICT ? 1'b0 : 1'b1, 0);
    bus.link_en = 1'b1;
    #1;
    for (int s = 0; s < 4; s++) begin
      run_slot(-1);
      check_slot($sformatf("retrain%0d", s), 0, 0, 32'hBCBCBCBC, 0, STRICT ? 1'b0 : 1'b1, 0);
    end
    run_slot(-1);
    check_slot("re_active", 0, 0, 32'h0, 0, STRICT ? 1'b0 : 1'b1, 1);

    // Reset 10 cycles into a granted slot.
    bus.valid_in1 = 1'b0;
    bus.data_in0  = 32'h5A5A5A5A;
    #1;
    run_slot(-1);
    check_slot("pre_rst", 1, 0, 32'h5A5A5A5A, 1, 0, 1);
    repeat (10) tick();
    reset = 1'b1;
    #1;
    check("mid_rst.data", bus.data_out, 32'h0);
    check("mid_rst.flags", {28'd0, bus.valid_out, bus.grant_id, bus.link_up, bus.ready_out0}, 32'h0);
    tick();
    reset = 1'b0;
    run_slot(-1);
    check_slot("post_rst", 0, 0, 32'hBCBCBCBC, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/phy_arbiter.md
PHY_ARBITER -- requirements
Module: phy_arbiter

Interface
REQ-001 Parameter SLOT_LEN, default 32: clk_32f cycles per word slot; the block SHALL accept values 2..256.
REQ-002 Parameter INIT_WORDS, default 4: number of training slots emitted before ACTIVE; the block SHALL accept values 1..255.
REQ-003 Parameter IDLE_WORD, default 32'hBCBCBCBC: training word driven on data_out during INIT.
REQ-004 clk_32f  input  1: the block's only clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1: asynchronous, active-high reset.
REQ-006 link_en  input  1: link enable, sampled only at slot boundaries.
REQ-007 data_in0  input  32: requester 0 word.
REQ-008 valid_in0  input  1: requester 0 word valid.
REQ-009 ready_out0  output  1: requester 0 word accepted this cycle.
REQ-010 data_in1  input  32: requester 1 word.
REQ-011 valid_in1  input  1: requester 1 word valid.
REQ-012 ready_out1  output  1: requester 1 word accepted this cycle.
REQ-013 data_out  output  32: word toward the PHY transmitter; registered.
REQ-014 valid_out  output  1: data_out carries requester data; registered.
REQ-015 grant_id  output  1: source requester of the current data_out word; registered.
REQ-016 link_up  output  1: high while the state is ACTIVE; registered.

Function
REQ-017 An 8-bit slot counter SHALL count 0..SLOT_LEN-1 and wrap to 0 in every state; the boundary is the cycle where count == SLOT_LEN-1.
REQ-018 States are IDLE, INIT and ACTIVE; state changes and all output-register updates SHALL occur only on the boundary clock edge, so outputs are held constant for exactly SLOT_LEN cycles.
REQ-019 IDLE: link_en=1 at a boundary -> INIT with init count 0; otherwise remain in IDLE with data_out=0 and valid_out=0.
REQ-020 INIT: data_out=IDLE_WORD, valid_out=0; the init count increments per boundary; at the boundary where the count equals INIT_WORDS-1 -> ACTIVE.
REQ-021 ACTIVE: at each boundary, if any valid_inN=1, one requester SHALL be selected and its word registered to data_out with valid_out=1 and grant_id=N; if neither is valid, data_out=0, valid_out=0 and grant_id is held.
REQ-022 ready_outN SHALL be combinational and high only in the ACTIVE boundary cycle in which requester N is selected; the transfer occurs when valid_inN and ready_outN are both high, and ready_outN is never high in any other cycle.
REQ-023 Requesters SHALL hold data_inN stable while valid_inN=1 until the transfer; the block SHALL NOT capture data outside the transfer cycle.
REQ-024 Latency: the transferred word appears on data_out on the clock edge that completes the handshake (one cycle after the boundary cycle begins).
REQ-025 Round-robin: a 1-bit last-grant pointer; when both are valid, the requester not equal to the pointer wins; the pointer updates only on a transfer.
REQ-026 link_en=0 at a boundary in INIT or ACTIVE -> IDLE, data_out=0, valid_out=0, no ready pulse; this takes precedence over arbitration in the same boundary.
REQ-027 link_up=1 exactly while the state register equals ACTIVE.

Reset
REQ-028 reset=1 SHALL asynchronously force: state IDLE, slot count 0, init count 0, pointer 1 (requester 0 wins first), data_out=0, valid_out=0, grant_id=0, link_up=0, ready_out0=ready_out1=0.
REQ-029 Reset asserted mid-slot SHALL discard any word in flight; after release, counting restarts from 0 and the first boundary occurs SLOT_LEN cycles later.

Configuration
REQ-030 Macro PHY_ARB_STRICT_PRIO_EN: when defined, requester 0 SHALL always win when both are valid and the pointer is unused; when undefined, the round-robin of REQ-025 applies.

Verification
REQ-031 Reset, link_en=1, SLOT_LEN=32, INIT_WORDS=4 -> 4 slots of data_out=32'hBCBCBCBC with valid_out=0, then link_up=1 at the 5th boundary edge.
REQ-032 ACTIVE, only valid_in0=1 with data 32'h12345678 -> ready_out0 pulses in one boundary cycle; data_out=32'h12345678, valid_out=1, grant_id=0 for 32 cycles.
REQ-033 ACTIVE, both valid continuously (A0=32'hA0A0A0A0, A1=32'hB1B1B1B1) -> grants 0,1,0,1 on consecutive slots; with PHY_ARB_STRICT_PRIO_EN -> grants 0,0,0,0.
REQ-034 ACTIVE, no valid -> data_out=0, valid_out=0, no ready pulses, grant_id unchanged.
REQ-035 link_en dropped mid-slot with both valid -> at the next boundary: IDLE, link_up=0, valid_out=0, no ready pulse; re-raising link_en -> INIT repeats 4 training slots.
REQ-036 reset pulsed 10 cycles into a granted slot -> all outputs are 0 immediately and the state is IDLE; the next boundary occurs 32 cycles after release.
